// File: rtl/avalon_st_pkg.sv
// Shared types and helpers for the Avalon-ST source, interface and sampler.
package avalon_st_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Width of the empty field for an N-byte beat; never narrower than one bit.
    function automatic int empty_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle: N-byte data with sop/eop/empty framing and rdy backpressure.
interface avalon_st_if
    import avalon_st_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 1
);
    localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             vld;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;
    logic                             rdy;

    modport source (output data, output vld, output sop, output eop, output empty, input rdy);
    modport sink   (input data, input vld, input sop, input eop, input empty, output rdy);

endinterface

// File: rtl/avalon_st_ramp_beat.sv
// Combinational byte-ramp beat former: byte i of beat k is seed + k*N + i (mod 256).
// Kept stand-alone so a receiving checker can regenerate the same payload.
module avalon_st_ramp_beat
    import avalon_st_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 1,
    parameter int BEAT_W              = 10
) (
    input  byte_t                            seed,
    input  logic [BEAT_W-1:0]                beat_idx,
    output logic [8*DATA_WIDTH_IN_BYTES-1:0] data
);

    // Only the low 8 bits of k*N matter, so the product is formed modulo 256.
    always_comb begin
        data = '0;
        for (int i = 0; i < DATA_WIDTH_IN_BYTES; i++) begin
            data[8*i +: 8] = seed
                           + byte_t'(beat_idx) * byte_t'(DATA_WIDTH_IN_BYTES)
                           + byte_t'(i);
        end
    end

endmodule

// File: rtl/avalon_st_pkt_gen.sv
// Avalon-ST packet source: sends one byte-ramp packet per accepted start,
// with sop/eop/empty framing, honouring rdy backpressure. All outputs registered.
module avalon_st_pkt_gen
    import avalon_st_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 1,
    parameter int MAX_PKT_BYTES       = 1024,
    localparam int LEN_W              = $clog2(MAX_PKT_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] pkt_len,
    input  byte_t            seed,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pkt_cnt,
    avalon_st_if.source      msg_out
);

    localparam int          N         = DATA_WIDTH_IN_BYTES;
    localparam int unsigned N_U       = DATA_WIDTH_IN_BYTES;
    localparam int          BEATS_MAX = (MAX_PKT_BYTES + N - 1) / N;
    localparam int          BEAT_W    = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;
    localparam int          EMPTY_W   = empty_width(N);
    localparam int          DATA_W    = 8 * N;

    state_e             state, state_next;
    byte_t              seed_q, seed_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [BEAT_W-1:0]  last_q, last_d;
    logic [EMPTY_W-1:0] empty_last_q, empty_last_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               vld_q, vld_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [EMPTY_W-1:0] empty_q, empty_d;
    logic               busy_d, done_d;
    logic [15:0]        pkt_cnt_d;

    logic [LEN_W-1:0]   len_sat;
    int unsigned        len_i, beats_i;
    logic [BEAT_W-1:0]  last_calc;
    logic [EMPTY_W-1:0] empty_calc;
    logic               accept, xfer, next_is_last;
    byte_t              ramp_seed;
    logic [BEAT_W-1:0]  ramp_idx;
    logic [DATA_W-1:0]  ramp_data;

    assign len_sat = (pkt_len > LEN_W'(MAX_PKT_BYTES)) ? LEN_W'(MAX_PKT_BYTES) : pkt_len;
    assign accept  = (state == IDLE) && start && (pkt_len != '0);
    assign xfer    = (state == SEND) && vld_q && msg_out.rdy;
    assign next_is_last = ((beat_q + BEAT_W'(1)) == last_q);

    // Beat count and tail padding of the requested packet, from the saturated length.
    always_comb begin
        len_i      = 32'(len_sat);
        beats_i    = (len_i + N_U - 1) / N_U;
        last_calc  = BEAT_W'(beats_i - 1);
        empty_calc = EMPTY_W'(beats_i * N_U - len_i);
    end

    // The former builds beat 0 from the live seed when starting, else the next beat.
    assign ramp_seed = (state == IDLE) ? seed : seed_q;
    assign ramp_idx  = (state == IDLE) ? '0 : beat_q + BEAT_W'(1);

    avalon_st_ramp_beat #(
        .DATA_WIDTH_IN_BYTES (N),
        .BEAT_W              (BEAT_W)
    ) u_ramp (
        .seed     (ramp_seed),
        .beat_idx (ramp_idx),
        .data     (ramp_data)
    );

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: leave IDLE on an accepted start, return after the eop handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SEND;
            SEND:    if (xfer && eop_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/next-register values: load beat 0 on start, advance only on a handshake.
    always_comb begin
        seed_d       = seed_q;
        beat_d       = beat_q;
        last_d       = last_q;
        empty_last_d = empty_last_q;
        data_d       = data_q;
        vld_d        = vld_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        empty_d      = empty_q;
        busy_d       = busy;
        done_d       = 1'b0;
        pkt_cnt_d    = pkt_cnt;
        if (accept) begin
            seed_d       = seed;
            beat_d       = '0;
            last_d       = last_calc;
            empty_last_d = empty_calc;
            data_d       = ramp_data;
            vld_d        = 1'b1;
            sop_d        = 1'b1;
            eop_d        = (last_calc == '0);
            empty_d      = (last_calc == '0) ? empty_calc : '0;
            busy_d       = 1'b1;
        end else if (xfer) begin
            if (eop_q) begin
                vld_d     = 1'b0;
                sop_d     = 1'b0;
                eop_d     = 1'b0;
                empty_d   = '0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                pkt_cnt_d = pkt_cnt + 16'd1;
            end else begin
                beat_d  = beat_q + BEAT_W'(1);
                data_d  = ramp_data;
                sop_d   = 1'b0;
                eop_d   = next_is_last;
                empty_d = next_is_last ? empty_last_q : '0;
            end
        end
    end

    // Registered outputs and packet context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q       <= '0;
            beat_q       <= '0;
            last_q       <= '0;
            empty_last_q <= '0;
            data_q       <= '0;
            vld_q        <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            empty_q      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pkt_cnt      <= '0;
        end else begin
            seed_q       <= seed_d;
            beat_q       <= beat_d;
            last_q       <= last_d;
            empty_last_q <= empty_last_d;
            data_q       <= data_d;
            vld_q        <= vld_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            empty_q      <= empty_d;
            busy         <= busy_d;
            done         <= done_d;
            pkt_cnt      <= pkt_cnt_d;
        end
    end

    assign msg_out.data  = data_q;
    assign msg_out.vld   = vld_q;
    assign msg_out.sop   = sop_q;
    assign msg_out.eop   = eop_q;
    assign msg_out.empty = empty_q;

endmodule

// File: tb/tb_avalon_st_pkt_gen.sv
// Bench for avalon_st_pkt_gen: one 1-byte-wide and one 4-byte-wide instance,
// expected beats queued at start and compared as the DUT presents them.
module tb_avalon_st_pkt_gen;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst1_n, rst4_n;
    logic        start1, start4;
    logic [10:0] len1;
    logic [4:0]  len4;
    logic [7:0]  seed1, seed4;
    logic        busy1, busy4, done1, done4;
    logic [15:0] cnt1, cnt4;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    beat_t q1[$];
    beat_t q4[$];
    beat_t m1, m4;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(1)) if1 ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) if4 ();

    avalon_st_pkt_gen #(.DATA_WIDTH_IN_BYTES(1), .MAX_PKT_BYTES(1024)) dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .pkt_len(len1), .seed(seed1),
        .busy(busy1), .done(done1), .pkt_cnt(cnt1), .msg_out(if1)
    );

    avalon_st_pkt_gen #(.DATA_WIDTH_IN_BYTES(4), .MAX_PKT_BYTES(16)) dut4 (
        .clk(clk), .rst_n(rst4_n), .start(start4), .pkt_len(len4), .seed(seed4),
        .busy(busy4), .done(done4), .pkt_cnt(cnt4), .msg_out(if4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the beats a packet of len bytes from seed s must produce on an n-byte bus.
    task automatic push_pkt(input int which, input logic [7:0] s, input int len);
        int n;
        int b;
        beat_t e;
        n = (which == 1) ? 1 : 4;
        b = (len + n - 1) / n;
        for (int k = 0; k < b; k++) begin
            e.data = '0;
            for (int i = 0; i < n; i++) e.data[8*i +: 8] = s + 8'(k*n + i);
            e.sop   = (k == 0);
            e.eop   = (k == b - 1);
            e.empty = (k == b - 1) ? 2'(b*n - len) : 2'd0;
            if (which == 1) q1.push_back(e);
            else            q4.push_back(e);
        end
    endtask

    task automatic wait_done1(input int maxc, input bit toggle, output int c);
        c = 0;
        while (!done1 && c < maxc) begin
            if (toggle) if1.rdy = ~if1.rdy;
            tick();
            c++;
        end
        check("done1_seen", 32'(done1), 32'(1));
        if1.rdy = 1'b1;
    endtask

    task automatic wait_done4(input int maxc, output int c);
        c = 0;
        while (!done4 && c < maxc) begin
            tick();
            c++;
        end
        check("done4_seen", 32'(done4), 32'(1));
    endtask

    // Every presented beat, stalled or not, must match the head of the queue.
    always @(negedge clk) begin
        if (rst1_n && if1.vld) begin
            if (q1.size() == 0) check("g1_extra_beat", 32'(if1.vld), 32'(0));
            else begin
                m1 = q1[0];
                check("g1_data",  32'(if1.data),  m1.data);
                check("g1_sop",   32'(if1.sop),   32'(m1.sop));
                check("g1_eop",   32'(if1.eop),   32'(m1.eop));
                check("g1_empty", 32'(if1.empty), 32'(0));
                if (if1.rdy) void'(q1.pop_front());
            end
        end
        if (rst4_n && if4.vld) begin
            if (q4.size() == 0) check("g4_extra_beat", 32'(if4.vld), 32'(0));
            else begin
                m4 = q4[0];
                check("g4_data",  32'(if4.data),  m4.data);
                check("g4_sop",   32'(if4.sop),   32'(m4.sop));
                check("g4_eop",   32'(if4.eop),   32'(m4.eop));
                check("g4_empty", 32'(if4.empty), 32'(m4.empty));
                if (if4.rdy) void'(q4.pop_front());
            end
        end
    end

    initial begin
        rst1_n = 1'b0; rst4_n = 1'b0;
        start1 = 1'b0; start4 = 1'b0;
        len1 = '0; len4 = '0; seed1 = '0; seed4 = '0;
        if1.rdy = 1'b1; if4.rdy = 1'b1;
        tick(); tick();

        // Reset state.
        check("rst_vld1",  32'(if1.vld),  32'(0));
        check("rst_sop1",  32'(if1.sop),  32'(0));
        check("rst_eop1",  32'(if1.eop),  32'(0));
        check("rst_data1", 32'(if1.data), 32'(0));
        check("rst_busy1", 32'(busy1),    32'(0));
        check("rst_done1", 32'(done1),    32'(0));
        check("rst_cnt1",  32'(cnt1),     32'(0));
        check("rst_vld4",  32'(if4.vld),  32'(0));
        check("rst_data4", 32'(if4.data), 32'(0));
        check("rst_empty4",32'(if4.empty),32'(0));
        check("rst_cnt4",  32'(cnt4),     32'(0));
        rst1_n = 1'b1; rst4_n = 1'b1;
        tick();

        // N=1, len 3, seed AA, rdy held high.
        push_pkt(1, 8'hAA, 3);
        start1 = 1'b1; len1 = 11'd3; seed1 = 8'hAA;
        tick();
        start1 = 1'b0;
        check("t1_first_vld",  32'(if1.vld),  32'(1));
        check("t1_first_sop",  32'(if1.sop),  32'(1));
        check("t1_first_data", 32'(if1.data), 32'hAA);
        check("t1_busy",       32'(busy1),    32'(1));
        wait_done1(20, 1'b0, cyc);
        check("t1_done_latency", 32'(cyc), 32'(3));
        check("t1_cnt",   32'(cnt1),  32'(1));
        check("t1_busy0", 32'(busy1), 32'(0));
        check("t1_vld0",  32'(if1.vld), 32'(0));
        check("t1_queue", 32'(q1.size()), 32'(0));

        // N=1, len 4, seed 10, rdy toggling every cycle.
        push_pkt(1, 8'h10, 4);
        if1.rdy = 1'b0;
        start1 = 1'b1; len1 = 11'd4; seed1 = 8'h10;
        tick();
        start1 = 1'b0;
        wait_done1(40, 1'b1, cyc);
        check("t2_cnt",   32'(cnt1), 32'(2));
        check("t2_queue", 32'(q1.size()), 32'(0));

        // Back-to-back: second start issued in the done cycle of the first.
        push_pkt(1, 8'h30, 2);
        start1 = 1'b1; len1 = 11'd2; seed1 = 8'h30;
        tick();
        start1 = 1'b0;
        wait_done1(20, 1'b0, cyc);
        check("b2b_cnt_a", 32'(cnt1), 32'(3));
        push_pkt(1, 8'h55, 1);
        start1 = 1'b1; len1 = 11'd1; seed1 = 8'h55;
        tick();
        start1 = 1'b0;
        check("b2b_sop",  32'(if1.sop),  32'(1));
        check("b2b_eop",  32'(if1.eop),  32'(1));
        check("b2b_data", 32'(if1.data), 32'h55);
        wait_done1(20, 1'b0, cyc);
        check("b2b_cnt_b", 32'(cnt1), 32'(4));

        // Asynchronous reset during the second beat of a 5-byte packet.
        push_pkt(1, 8'h70, 5);
        start1 = 1'b1; len1 = 11'd5; seed1 = 8'h70;
        tick();
        start1 = 1'b0;
        tick();
        #1 rst1_n = 1'b0;
        #1;
        check("arst_vld",  32'(if1.vld), 32'(0));
        check("arst_sop",  32'(if1.sop), 32'(0));
        check("arst_eop",  32'(if1.eop), 32'(0));
        check("arst_busy", 32'(busy1),   32'(0));
        check("arst_cnt",  32'(cnt1),    32'(0));
        check("arst_popped_one", 32'(q1.size()), 32'(4));
        q1.delete();
        rst1_n = 1'b1;
        tick();
        push_pkt(1, 8'h42, 2);
        start1 = 1'b1; len1 = 11'd2; seed1 = 8'h42;
        tick();
        start1 = 1'b0;
        check("arst_new_sop",  32'(if1.sop),  32'(1));
        check("arst_new_data", 32'(if1.data), 32'h42);
        wait_done1(20, 1'b0, cyc);
        check("arst_new_cnt", 32'(cnt1), 32'(1));

        // N=4, len 6, seed FE: wrapping ramp, empty 2 on the last beat.
        push_pkt(4, 8'hFE, 6);
        start4 = 1'b1; len4 = 5'd6; seed4 = 8'hFE;
        tick();
        start4 = 1'b0;
        check("n4_b0_data", if4.data, 32'h0100FFFE);
        wait_done4(20, cyc);
        check("n4_latency", 32'(cyc), 32'(2));
        check("n4_cnt",     32'(cnt4), 32'(1));

        // N=4, len 4: single beat, held by backpressure while a second start is ignored.
        push_pkt(4, 8'h20, 4);
        if4.rdy = 1'b0;
        start4 = 1'b1; len4 = 5'd4; seed4 = 8'h20;
        tick();
        check("single_sop",   32'(if4.sop),   32'(1));
        check("single_eop",   32'(if4.eop),   32'(1));
        check("single_empty", 32'(if4.empty), 32'(0));
        len4 = 5'd3; seed4 = 8'h99;
        tick();
        start4 = 1'b0;
        tick();
        check("single_held_busy", 32'(busy4), 32'(1));
        if4.rdy = 1'b1;
        wait_done4(20, cyc);
        check("single_cnt", 32'(cnt4), 32'(2));
        tick(); tick(); tick();
        check("ignored_vld", 32'(if4.vld), 32'(0));
        check("ignored_cnt", 32'(cnt4),    32'(2));

        // Zero-length start produces nothing.
        start4 = 1'b1; len4 = 5'd0; seed4 = 8'h77;
        tick();
        start4 = 1'b0;
        check("zero_vld",  32'(if4.vld), 32'(0));
        check("zero_busy", 32'(busy4),   32'(0));
        tick();
        check("zero_done", 32'(done4), 32'(0));
        check("zero_cnt",  32'(cnt4),  32'(2));

        // Length above MAX_PKT_BYTES (16) is clamped: 4 full beats, empty 0.
        push_pkt(4, 8'h00, 16);
        start4 = 1'b1; len4 = 5'd20; seed4 = 8'h00;
        tick();
        start4 = 1'b0;
        wait_done4(20, cyc);
        check("sat_latency", 32'(cyc), 32'(4));
        check("sat_cnt",     32'(cnt4), 32'(3));

        tick();
        check("end_queue1", 32'(q1.size()), 32'(0));
        check("end_queue4", 32'(q4.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/avalon_st_pkt_gen.md
Name: avalon_st_pkt_gen

Overview:
Avalon-ST packet source. It drives a complete packet onto an avalon_st_if with correct sop/eop/empty framing and honours sink backpressure (rdy). It is the transmitting end that feeds stream consumers such as avalon_sampler, and is used as a traffic generator in bring-up and self-test. Packet payload is a deterministic byte ramp starting at a programmable seed, so the receiving side can check it.

Parameters:
DATA_WIDTH_IN_BYTES, 1, bytes per beat (N); must match the attached interface.
MAX_PKT_BYTES, 1024, largest accepted packet length in bytes.

Ports:
clk  input  1  clock, all logic on rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  one-cycle request to send a packet; sampled only in IDLE.
pkt_len  input  LEN_W  packet length in bytes. LEN_W = $clog2(MAX_PKT_BYTES+1).
seed  input  8  value of the first payload byte.
busy  output  1  high from the cycle after an accepted start until the last beat is accepted.
done  output  1  one-cycle pulse, the cycle after the last-beat handshake.
pkt_cnt  output  16  number of completed packets, wraps at 2^16.
msg_out  avalon_st_if source modport  -  carries data[N bytes], vld, sop, eop and empty as outputs, and rdy as input.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately.
  - vld, sop, eop, busy and done are 0; data, empty and pkt_cnt are 0.
  - Reset mid-packet abandons the packet; no eop is emitted.
- States: IDLE and SEND.
- IDLE:
  - start=1 and pkt_len!=0: latch the length and seed, then enter SEND.
  - pkt_len > MAX_PKT_BYTES is saturated to MAX_PKT_BYTES.
  - start with pkt_len=0 is ignored: no beat, no done.
- Latency: first beat has vld=1 and sop=1 in the cycle after start. All outputs are registered.
- Beats: total beats B = ceil(len/N).
  - Byte i of beat k: data[i] = (seed + k*N + i) mod 256. data[0] is the first byte on the wire.
- Handshake: a beat transfers on a clock edge where vld=1 and rdy=1.
  - While vld=1 and rdy=0, data, sop, eop and empty hold stable.
  - vld is never withdrawn before the transfer.
  - vld does not depend combinationally on rdy.
- sop is 1 only on beat 0. eop is 1 only on beat B-1.
- empty = B*N - len on the eop beat and 0 otherwise. Width is max(1,$clog2(N)); always 0 when N=1.
- Single-beat packet: sop=1 and eop=1 on the same beat.
- After the eop beat transfers:
  - next cycle: vld=0, busy=0, done=1, pkt_cnt increments, state returns to IDLE.
  - The earliest next start is accepted in that same done cycle, so the next sop appears one cycle later.
  - Minimum gap between packets: 1 idle cycle.
- start while in SEND is ignored; there is no queuing.
- Beat counter is sized for ceil(MAX_PKT_BYTES/N) beats and does not wrap within a packet.
- pkt_cnt wraps 0xFFFF -> 0x0000 without side effects.
- Payload byte arithmetic is modulo 256 and wraps freely, e.g. seed 0xFE gives bytes FE, FF, 00, ...

Decomposition:
- Package avalon_st_pkg (shared with the interface and the sampler) holds:
  - localparam function empty_width(N);
  - typedef byte_t;
  - typedef state_e {IDLE, SEND}.
- The byte-ramp beat former becomes a sub-module avalon_st_ramp_beat. It is combinational: it takes seed and beat index and produces the N-byte data vector, so it can be reused by a matching checker.
- The FSM, counters and output registers stay in the top.

Test Plan:
- N=1, len=3, seed=0xAA, rdy=1 constant -> beats AA(sop), AB, AC(eop, empty=0) on consecutive cycles; done one cycle after; pkt_cnt=1.
- N=1, len=4, seed=0x10, rdy toggling 0/1 each cycle -> each byte held until rdy=1. Sequence 10,11,12,13 with no duplicates or drops; sop only on 10 and eop only on 13.
- N=4, len=6, seed=0xFE -> beat0 {FE,FF,00,01} with sop; beat1 {02,03,04,05} with eop and empty=2.
- N=4, len=4 -> single beat with sop=eop=1 and empty=0. Also start with len=0 -> no vld and no done; start during SEND -> ignored, pkt_cnt increments once.
- Reset (rst_n low) asynchronously between clock edges during the second beat of a 5-byte packet -> vld, sop and eop drop to 0 immediately without waiting for a clock edge. After release, a new start yields a fresh sop with correct seed bytes.
- Back-to-back: start asserted in the done cycle -> sop of the second packet exactly 2 cycles after the first packet's eop transfer; pkt_cnt=2.
